// File: rtl/caxi4interconnect_open_trans_tracker.sv
// Per-master outstanding-transaction thread table with a zero-latency ID lookup.
// Optional sticky error flag output trkErr when CAXI4INTERCONNECT_TRK_ERR_EN is defined.
module caxi4interconnect_open_trans_tracker #(
  parameter int NUM_SLAVES       = 4,
  parameter int NUM_SLAVES_WIDTH = 2,
  parameter int MASTERID_WIDTH   = 4,
  parameter int NUM_THREADS      = 2,
  parameter int OPEN_TRANS_MAX   = 3,
  parameter int OPEN_TRANS_WIDTH = 2
) (
  input  logic                        sysClk,
  input  logic                        sysReset,
  input  logic [MASTERID_WIDTH-1:0]   currTransID,
  output logic                        threadAvail,
  output logic                        threadValid,
  output logic [OPEN_TRANS_WIDTH-1:0] threadCount,
  output logic [NUM_SLAVES_WIDTH-1:0] threadSlaveID,
  input  logic                        transInc,
  input  logic [MASTERID_WIDTH-1:0]   incTransID,
  input  logic [NUM_SLAVES_WIDTH-1:0] incSlaveID,
  input  logic                        transDec,
  input  logic [MASTERID_WIDTH-1:0]   decTransID,
`ifdef CAXI4INTERCONNECT_TRK_ERR_EN
  output logic                        trkErr,
`endif
  output logic                        noOpenTrans
);

  localparam int IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam logic [OPEN_TRANS_WIDTH-1:0] CNT_MAX = OPEN_TRANS_MAX[OPEN_TRANS_WIDTH-1:0];
  localparam logic [OPEN_TRANS_WIDTH-1:0] CNT_ONE = OPEN_TRANS_WIDTH'(1);

  logic [NUM_THREADS-1:0]                       valid_q, valid_d;
  logic [NUM_THREADS-1:0][MASTERID_WIDTH-1:0]   id_q, id_d;
  logic [NUM_THREADS-1:0][NUM_SLAVES_WIDTH-1:0] slv_q, slv_d;
  logic [NUM_THREADS-1:0][OPEN_TRANS_WIDTH-1:0] cnt_q, cnt_d;
  logic                                         no_open_q;

  logic [NUM_THREADS-1:0] cur_hit, inc_hit, dec_hit;
  logic [IDX_W-1:0]       cur_idx, inc_idx, dec_idx, free_idx;
  logic                   inc_any, dec_any, free_any, same_id, err;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_match
      assign cur_hit[gi] = valid_q[gi] && (id_q[gi] == currTransID);
      assign inc_hit[gi] = valid_q[gi] && (id_q[gi] == incTransID);
      assign dec_hit[gi] = valid_q[gi] && (id_q[gi] == decTransID);
    end
  endgenerate

  assign inc_any  = |inc_hit;
  assign dec_any  = |dec_hit;
  assign free_any = ~&valid_q;
  assign same_id  = transInc && transDec && (incTransID == decTransID);

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    cur_idx  = '0;
    inc_idx  = '0;
    dec_idx  = '0;
    free_idx = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (cur_hit[i]) cur_idx  = IDX_W'(i);
      if (inc_hit[i]) inc_idx  = IDX_W'(i);
      if (dec_hit[i]) dec_idx  = IDX_W'(i);
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign threadAvail   = free_any;
  assign threadValid   = |cur_hit;
  assign threadCount   = (|cur_hit) ? cnt_q[cur_idx] : '0;
  assign threadSlaveID = (|cur_hit) ? slv_q[cur_idx] : '0;
  assign noOpenTrans   = no_open_q;

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    slv_d   = slv_q;
    cnt_d   = cnt_q;
    err     = 1'b0;
    if (same_id) begin
      // Matched inc+dec cancel; without a slot the inc allocates and the dec is orphaned.
      if (inc_any) begin
        if (slv_q[inc_idx] != incSlaveID) err = 1'b1;
      end else begin
        err = 1'b1;
        if (free_any) begin
          valid_d[free_idx] = 1'b1;
          id_d[free_idx]    = incTransID;
          slv_d[free_idx]   = incSlaveID;
          cnt_d[free_idx]   = CNT_ONE;
        end
      end
    end else begin
      if (transInc) begin
        if (inc_any) begin
          if (slv_q[inc_idx] != incSlaveID) begin
            err = 1'b1;
          end else if (cnt_q[inc_idx] == CNT_MAX) begin
            err = 1'b1;
          end else begin
            cnt_d[inc_idx] = cnt_q[inc_idx] + CNT_ONE;
          end
        end else if (free_any) begin
          valid_d[free_idx] = 1'b1;
          id_d[free_idx]    = incTransID;
          slv_d[free_idx]   = incSlaveID;
          cnt_d[free_idx]   = CNT_ONE;
        end else begin
          err = 1'b1;
        end
      end
      if (transDec) begin
        if (dec_any) begin
          if (cnt_q[dec_idx] <= CNT_ONE) begin
            cnt_d[dec_idx]   = '0;
            valid_d[dec_idx] = 1'b0;
          end else begin
            cnt_d[dec_idx] = cnt_q[dec_idx] - CNT_ONE;
          end
        end else begin
          err = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sysClk or negedge sysReset) begin
    if (!sysReset) begin
      valid_q   <= '0;
      id_q      <= '0;
      slv_q     <= '0;
      cnt_q     <= '0;
      no_open_q <= 1'b1;
    end else begin
      valid_q   <= valid_d;
      id_q      <= id_d;
      slv_q     <= slv_d;
      cnt_q     <= cnt_d;
      no_open_q <= ~|valid_d;
    end
  end

`ifdef CAXI4INTERCONNECT_TRK_ERR_EN
  logic trk_err_q;

  always_ff @(posedge sysClk or negedge sysReset) begin
    if (!sysReset) trk_err_q <= 1'b0;
    else if (err)  trk_err_q <= 1'b1;
  end

  assign trkErr = trk_err_q;
`else
  logic unused_err;
  assign unused_err = err;
`endif

  logic unused_params;
  assign unused_params = (NUM_SLAVES > 0);

endmodule

// File: tb/tb_caxi4interconnect_open_trans_tracker.sv
// Self-checking bench: directed scenarios plus random inc/dec traffic against an ID-indexed model.
module tb_caxi4interconnect_open_trans_tracker;

  localparam int NT = 2;
  localparam int OMAX = 3;

  logic       sysClk = 1'b0;
  logic       sysReset = 1'b0;
  logic [3:0] currTransID = '0;
  logic       threadAvail, threadValid, noOpenTrans;
  logic [1:0] threadCount, threadSlaveID;
  logic       transInc = 1'b0, transDec = 1'b0;
  logic [3:0] incTransID = '0, decTransID = '0;
  logic [1:0] incSlaveID = '0;
`ifdef CAXI4INTERCONNECT_TRK_ERR_EN
  logic       trkErr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model: per-ID outstanding count and target slave; slot positions are irrelevant externally.
  int m_cnt[16];
  int m_slv[16];
  bit m_err;

  caxi4interconnect_open_trans_tracker dut (
    .sysClk       (sysClk),
    .sysReset     (sysReset),
    .currTransID  (currTransID),
    .threadAvail  (threadAvail),
    .threadValid  (threadValid),
    .threadCount  (threadCount),
    .threadSlaveID(threadSlaveID),
    .transInc     (transInc),
    .incTransID   (incTransID),
    .incSlaveID   (incSlaveID),
    .transDec     (transDec),
    .decTransID   (decTransID),
`ifdef CAXI4INTERCONNECT_TRK_ERR_EN
    .trkErr       (trkErr),
`endif
    .noOpenTrans  (noOpenTrans)
  );

  always #5 sysClk = ~sysClk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int occupied();
    int o = 0;
    for (int i = 0; i < 16; i++) if (m_cnt[i] > 0) o++;
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_cnt[i] = 0;
      m_slv[i] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_edge(input bit inc, input int iid, input int isl, input bit dec, input int did);
    int o;
    o = occupied();
    if (inc && dec && iid == did) begin
      if (m_cnt[iid] > 0) begin
        if (m_slv[iid] != isl) m_err = 1'b1;
      end else begin
        m_err = 1'b1;
        if (o < NT) begin
          m_cnt[iid] = 1;
          m_slv[iid] = isl;
        end
      end
    end else begin
      if (inc) begin
        if (m_cnt[iid] > 0) begin
          if (m_slv[iid] != isl) m_err = 1'b1;
          else if (m_cnt[iid] == OMAX) m_err = 1'b1;
          else m_cnt[iid]++;
        end else if (o < NT) begin
          m_cnt[iid] = 1;
          m_slv[iid] = isl;
        end else begin
          m_err = 1'b1;
        end
      end
      if (dec) begin
        if (m_cnt[did] > 0) m_cnt[did]--;
        else m_err = 1'b1;
      end
    end
  endtask

  task automatic look(input int id);
    currTransID = 4'(id);
    #1;
    check_eq($sformatf("valid[%0d]", id), 32'(threadValid), 32'(m_cnt[id] > 0));
    check_eq($sformatf("count[%0d]", id), 32'(threadCount), 32'(m_cnt[id]));
    check_eq($sformatf("slave[%0d]", id), 32'(threadSlaveID), (m_cnt[id] > 0) ? 32'(m_slv[id]) : 32'd0);
  endtask

  task automatic check_global(input string where);
    check_eq({where, ".avail"}, 32'(threadAvail), 32'(occupied() < NT));
    check_eq({where, ".noOpen"}, 32'(noOpenTrans), 32'(occupied() == 0));
`ifdef CAXI4INTERCONNECT_TRK_ERR_EN
    check_eq({where, ".trkErr"}, 32'(trkErr), 32'(m_err));
`endif
  endtask

  // One clock: drive, take the edge, update model, then check state and two lookups.
  task automatic cyc(input bit inc, input int iid, input int isl, input bit dec, input int did, input int probe);
    transInc   = inc;
    incTransID = 4'(iid);
    incSlaveID = 2'(isl);
    transDec   = dec;
    decTransID = 4'(did);
    @(posedge sysClk);
    model_edge(inc, iid, isl, dec, did);
    #1;
    transInc = 1'b0;
    transDec = 1'b0;
    $display("[TB] t=%0t inc=%0b id=%0d slv=%0d dec=%0b id=%0d", $time, inc, iid, isl, dec, did);
    check_global("cyc");
    look(iid);
    look(probe);
    @(negedge sysClk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge sysClk);
    check_global("reset");
    look(0);
    look(5);
    sysReset = 1'b1;
    @(negedge sysClk);

    // Single thread lifecycle with saturation
    cyc(1, 5, 2, 0, 0, 5);
    cyc(1, 5, 2, 0, 0, 5);
    cyc(1, 5, 2, 0, 0, 5);
    cyc(1, 5, 2, 0, 0, 5);
    check_eq("sat.count", 32'(threadCount), 32'd3);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 5, 5);
    check_eq("life.noOpen", 32'(noOpenTrans), 32'd1);

    // Slot exhaustion; freed slot visible only after the edge
    cyc(1, 1, 0, 0, 0, 1);
    cyc(1, 2, 3, 0, 0, 1);
    check_eq("full.avail", 32'(threadAvail), 32'd0);
    cyc(1, 3, 1, 0, 0, 2);
    transDec = 1'b1;
    decTransID = 4'd1;
    #1;
    check_eq("dec.same_cycle_avail", 32'(threadAvail), 32'd0);
    transDec = 1'b0;
    cyc(0, 0, 0, 1, 1, 1);
    check_eq("dec.next_cycle_avail", 32'(threadAvail), 32'd1);
    cyc(0, 0, 0, 1, 2, 2);

    // Simultaneous inc/dec
    cyc(1, 4, 1, 0, 0, 4);
    cyc(1, 4, 1, 0, 0, 4);
    cyc(1, 4, 1, 1, 4, 4);
    check_eq("simul.count", 32'(threadCount), 32'd2);
    cyc(0, 0, 0, 1, 4, 4);
    cyc(1, 6, 3, 1, 4, 4);
    cyc(0, 0, 0, 1, 6, 6);

    // Unknown decrement and slave mismatch
    cyc(0, 0, 0, 1, 7, 7);
    cyc(1, 5, 2, 0, 0, 5);
    cyc(1, 5, 1, 0, 0, 5);
    check_eq("mismatch.slave", 32'(threadSlaveID), 32'd2);
    cyc(0, 0, 0, 1, 5, 5);

    // Random traffic over a narrow ID range to provoke hits, saturation and exhaustion
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 99) < 55), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
          ($urandom_range(0, 99) < 45), int'($urandom_range(0, 4)), int'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-cycle with two open threads
    for (int i = 0; i < 16; i++) if (m_cnt[i] > 0) begin
      while (m_cnt[i] > 0) cyc(0, 0, 0, 1, i, i);
    end
    cyc(1, 1, 0, 0, 0, 1);
    cyc(1, 2, 1, 0, 0, 2);
    currTransID = 4'd1;
    @(posedge sysClk);
    #3;
    sysReset = 1'b0;
    model_reset();
    #1;
    check_global("async_rst");
    check_eq("async_rst.valid", 32'(threadValid), 32'd0);
    check_eq("async_rst.count", 32'(threadCount), 32'd0);
    check_eq("async_rst.slave", 32'(threadSlaveID), 32'd0);
    @(negedge sysClk);
    sysReset = 1'b1;
    cyc(0, 0, 0, 1, 2, 2);
    cyc(1, 3, 2, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
